pci_rq_rc_latency_mon: RTL
==========================

// Module: pci_rq_rc_latency_mon
// PURPOSE
//  Passive requester-side perf monitor: snoops the RQ (requester request) and RC (requester completion)
//  AXI-S interfaces at the PCIe core boundary. Timestamps non-posted memory reads by tag on RQ and matches
//  them against RC completions. Reports read round-trip latency min/max/sum/count, outstanding reads and anomalies.
//  Counterpart of the completer-side PA counters; results go to the same PA register block.
// PARAMETERS
//  C_DATA_WIDTH  512  RQ/RC tdata width (descriptor in beat 0, straddle disabled)
//  TAG_WIDTH     8    tracked tag bits; table depth 2**TAG_WIDTH
//  TS_WIDTH      32   free-running timestamp and latency width
// PORTS
//  user_clk               in   1             clock
//  reset_n                in   1             async active-low reset
//  s_axis_rq_mon_tvalid/tready/tlast  in  1 each  RQ handshake snoop
//  s_axis_rq_mon_tdata    in   C_DATA_WIDTH  RQ data snoop
//  m_axis_rc_mon_tvalid/tready/tlast  in  1 each  RC handshake snoop
//  m_axis_rc_mon_tdata    in   C_DATA_WIDTH  RC data snoop
//  pa_count_reset         in   1             1: clear stats and tag table (sync)
//  pa_count_enable        in   1             1: capture issues / update stats
//  rd_lat_min             out  TS_WIDTH      minimum latency (cycles)
//  rd_lat_max             out  TS_WIDTH      maximum latency
//  rd_lat_sum             out  64            sum of latencies
//  rd_lat_count           out  32            matched completions
//  rd_outstanding         out  TAG_WIDTH+1   valid table entries
//  tag_reuse_count        out  32            issue on already-valid tag
//  unexpected_cmp_count   out  32            closing completion on invalid tag
//  cmp_err_count          out  32            completions with nonzero error code
// BEHAVIOUR
//  - Reset (reset_n=0 or pa_count_reset=1): min=all-ones, all other outputs 0, all valid bits 0; timer cleared by reset_n only.
//  - Stage 1: register all snooped inputs. SOP flag per side: set at reset and after tvalid&tready&tlast;
//    cleared after tvalid&tready without tlast.
//  - Stage 2 (extract): beat at SOP&tvalid&tready. RQ: req_type=tdata[78:75], tag=tdata[96+:TAG_WIDTH];
//    tracked issue iff req_type==4'b0000 (MemRd). RC: tag=tdata[64+:TAG_WIDTH], err=tdata[15:12],
//    req_done=tdata[30]; closing iff req_done|(err!=0). Latch timer value with each event.
//  - Stage 3: read table for RC tag; latency = ts_now - ts_entry mod 2**TS_WIDTH (wrap-safe).
//  - Stage 4: update stats/table. Outputs reflect a beat 4 cycles after its handshake on the snoop port.
//  - Issue (enable=1): write ts, set valid; if already valid -> tag_reuse_count+1, overwrite, outstanding unchanged;
//    else outstanding+1. Issue with enable=0 ignored.
//  - Closing completion, entry valid: clear valid, outstanding-1; if enable: count+1, sum+=lat, min/max update.
//    Entry invalid: unexpected_cmp_count+1 (if enable), nothing else. Non-closing (partial) completion: no action.
//  - err!=0 on any RC SOP: cmp_err_count+1 (if enable).
//  - Same tag issue+close same cycle: close evaluated against old entry first, then issue writes new entry
//    (valid stays 1, outstanding net unchanged). Different tags same cycle: both applied.
//  - Read-after-write in table between stages 3/4 must be forwarded (back-to-back issue then close on same tag).
//  - 32-bit counters wrap; rd_lat_sum wraps at 2**64; outstanding cannot exceed 2**TAG_WIDTH.
//  - pa_count_reset has priority over same-cycle events; in-flight pipeline events after it apply to cleared state.
// STRUCTURE
//  - Package pci_pa_pkg: descriptor bit positions (req type, RQ/RC tag, err code, req_done), REQ type
//    constants shared with the completer-side counters.
//  - Sub-module pci_pa_tag_table: 2**TAG_WIDTH x TS_WIDTH timestamp RAM (distributed) + valid flop vector,
//    one write, one read port, bulk valid clear.
// TESTING
//  - MemRd tag 5 at T, closing RC tag 5 at T+100 -> count=1, min=max=sum=100, outstanding 1->0.
//  - Reads tags 1,2,3; completions latencies 40,10,70 -> min=10, max=70, sum=120, count=3, outstanding=0.
//  - RC closing tag 9 never issued -> unexpected_cmp_count=1, stats unchanged; RC err=4'h1 -> cmp_err_count=1.
//  - Issue tag 7 twice without completion -> tag_reuse_count=1, outstanding=1; latency from second issue.
//  - Timer preloaded near 2**32-10, completion 30 cycles later -> latency=30; partial RC (req_done=0) ignored.
//  - Same-cycle close+reissue tag 3, pa_count_reset mid-burst, enable=0 issues -> all counters per rules above.

Source files
------------

// File: rtl/pci_pa_pkg.sv
// Shared descriptor layout and request-type encodings for the PCIe performance-analysis counters.
package pci_pa_pkg;

  localparam int unsigned REQ_TYPE_W      = 4;
  localparam int unsigned RQ_REQ_TYPE_LSB = 75;
  localparam int unsigned RQ_TAG_LSB      = 96;
  localparam int unsigned RC_TAG_LSB      = 64;
  localparam int unsigned RC_ERR_LSB      = 12;
  localparam int unsigned RC_ERR_W        = 4;
  localparam int unsigned RC_REQ_DONE_BIT = 30;
  localparam int unsigned SUM_W           = 64;
  localparam int unsigned CNT_W           = 32;

  typedef enum logic [REQ_TYPE_W-1:0] {
    REQ_MEM_RD        = 4'b0000,
    REQ_MEM_WR        = 4'b0001,
    REQ_IO_RD         = 4'b0010,
    REQ_IO_WR         = 4'b0011,
    REQ_MEM_FETCH_ADD = 4'b0100,
    REQ_MEM_SWAP      = 4'b0101,
    REQ_MEM_CAS       = 4'b0110,
    REQ_MEM_LK_RD     = 4'b0111,
    REQ_CFG_RD0       = 4'b1000,
    REQ_CFG_RD1       = 4'b1001,
    REQ_CFG_WR0       = 4'b1010,
    REQ_CFG_WR1       = 4'b1011,
    REQ_MSG           = 4'b1100,
    REQ_MSG_VEND      = 4'b1101,
    REQ_MSG_ATS       = 4'b1110,
    REQ_RSVD          = 4'b1111
  } req_type_e;

  // Only plain memory reads are timed for round-trip latency.
  function automatic logic is_tracked_read(input logic [REQ_TYPE_W-1:0] req_type);
    return req_type == REQ_MEM_RD;
  endfunction

endpackage

// File: rtl/pci_pa_tag_table.sv
// Per-tag issue timestamp store: distributed RAM for timestamps plus a flop vector of valid bits.
module pci_pa_tag_table #(
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned TS_WIDTH  = 32
) (
  input  logic                      user_clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [TAG_WIDTH-1:0]      wr_tag,
  input  logic [TS_WIDTH-1:0]       wr_ts,
  input  logic                      clr_en,
  input  logic [TAG_WIDTH-1:0]      clr_tag,
  input  logic                      bulk_clr,
  input  logic [TAG_WIDTH-1:0]      rd_tag,
  output logic [TS_WIDTH-1:0]       rd_ts_c,
  output logic [(1<<TAG_WIDTH)-1:0] valid
);

  localparam int unsigned DEPTH = 1 << TAG_WIDTH;

  logic [TS_WIDTH-1:0] ts_mem [DEPTH];
  logic [DEPTH-1:0]    valid_nxt;

  always_ff @(posedge user_clk) begin
    if (wr_en) ts_mem[wr_tag] <= wr_ts;
  end

  assign rd_ts_c = ts_mem[rd_tag];

  // Clear is applied before set so a same-tag close+reissue leaves the entry valid.
  always_comb begin
    valid_nxt = valid;
    if (bulk_clr) begin
      valid_nxt = '0;
    end else begin
      if (clr_en) valid_nxt[clr_tag] = 1'b0;
      if (wr_en)  valid_nxt[wr_tag]  = 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) valid <= '0;
    else          valid <= valid_nxt;
  end

endmodule

// File: rtl/pci_rq_rc_latency_mon.sv
// Requester-side read latency monitor: timestamps MemRd issues on RQ by tag and matches RC completions.
module pci_rq_rc_latency_mon
  import pci_pa_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned TS_WIDTH     = 32
) (
  input  logic                    user_clk,
  input  logic                    reset_n,
  input  logic                    s_axis_rq_mon_tvalid,
  input  logic                    s_axis_rq_mon_tready,
  input  logic                    s_axis_rq_mon_tlast,
  input  logic [C_DATA_WIDTH-1:0] s_axis_rq_mon_tdata,
  input  logic                    m_axis_rc_mon_tvalid,
  input  logic                    m_axis_rc_mon_tready,
  input  logic                    m_axis_rc_mon_tlast,
  input  logic [C_DATA_WIDTH-1:0] m_axis_rc_mon_tdata,
  input  logic                    pa_count_reset,
  input  logic                    pa_count_enable,
  output logic [TS_WIDTH-1:0]     rd_lat_min,
  output logic [TS_WIDTH-1:0]     rd_lat_max,
  output logic [63:0]             rd_lat_sum,
  output logic [31:0]             rd_lat_count,
  output logic [TAG_WIDTH:0]      rd_outstanding,
  output logic [31:0]             tag_reuse_count,
  output logic [31:0]             unexpected_cmp_count,
  output logic [31:0]             cmp_err_count
);

  localparam int unsigned OUT_W = TAG_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << TAG_WIDTH;

  // Stage 1: snooped handshake and descriptor fields
  logic                  rq_hs_q, rq_last_q, rq_sop;
  logic [REQ_TYPE_W-1:0] rq_type_q;
  logic [TAG_WIDTH-1:0]  rq_tag_q;
  logic                  rc_hs_q, rc_last_q, rc_sop, rc_done_q;
  logic [RC_ERR_W-1:0]   rc_err_q;
  logic [TAG_WIDTH-1:0]  rc_tag_q;
  logic [TS_WIDTH-1:0]   timer;
  logic                  unused_tdata;

  assign unused_tdata = ^{s_axis_rq_mon_tdata, m_axis_rc_mon_tdata};

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_hs_q   <= 1'b0;
      rq_last_q <= 1'b0;
      rq_type_q <= '0;
      rq_tag_q  <= '0;
      rc_hs_q   <= 1'b0;
      rc_last_q <= 1'b0;
      rc_done_q <= 1'b0;
      rc_err_q  <= '0;
      rc_tag_q  <= '0;
      rq_sop    <= 1'b1;
      rc_sop    <= 1'b1;
      timer     <= '0;
    end else begin
      rq_hs_q   <= s_axis_rq_mon_tvalid & s_axis_rq_mon_tready;
      rq_last_q <= s_axis_rq_mon_tlast;
      rq_type_q <= s_axis_rq_mon_tdata[RQ_REQ_TYPE_LSB +: REQ_TYPE_W];
      rq_tag_q  <= s_axis_rq_mon_tdata[RQ_TAG_LSB +: TAG_WIDTH];
      rc_hs_q   <= m_axis_rc_mon_tvalid & m_axis_rc_mon_tready;
      rc_last_q <= m_axis_rc_mon_tlast;
      rc_done_q <= m_axis_rc_mon_tdata[RC_REQ_DONE_BIT];
      rc_err_q  <= m_axis_rc_mon_tdata[RC_ERR_LSB +: RC_ERR_W];
      rc_tag_q  <= m_axis_rc_mon_tdata[RC_TAG_LSB +: TAG_WIDTH];
      if (rq_hs_q) rq_sop <= rq_last_q;
      if (rc_hs_q) rc_sop <= rc_last_q;
      timer     <= timer + TS_WIDTH'(1);
    end
  end

  // Stage 2: descriptor-beat events stamped with the timer
  logic                 s2_iss_v, s2_rc_v, s2_rc_close, s2_rc_err_nz;
  logic [TAG_WIDTH-1:0] s2_iss_tag, s2_rc_tag;
  logic [TS_WIDTH-1:0]  s2_ts;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_iss_v     <= 1'b0;
      s2_iss_tag   <= '0;
      s2_rc_v      <= 1'b0;
      s2_rc_close  <= 1'b0;
      s2_rc_err_nz <= 1'b0;
      s2_rc_tag    <= '0;
      s2_ts        <= '0;
    end else begin
      s2_iss_v     <= rq_hs_q & rq_sop & is_tracked_read(rq_type_q);
      s2_iss_tag   <= rq_tag_q;
      s2_rc_v      <= rc_hs_q & rc_sop;
      s2_rc_close  <= rc_done_q | (rc_err_q != '0);
      s2_rc_err_nz <= rc_err_q != '0;
      s2_rc_tag    <= rc_tag_q;
      s2_ts        <= timer;
    end
  end

  // Stage 3: table lookup for the completion tag, with bypass of the write landing this cycle
  logic                 s3_iss_v, s3_rc_v, s3_rc_close, s3_rc_err_nz;
  logic [TAG_WIDTH-1:0] s3_iss_tag, s3_rc_tag;
  logic [TS_WIDTH-1:0]  s3_iss_ts, s3_lat;
  logic [TS_WIDTH-1:0]  tbl_rd_ts_c, ent_ts_c;
  logic [DEPTH-1:0]     tbl_valid;
  logic                 tbl_wr_en_c, rc_close_c, rc_hit_c, iss_was_valid_c;

  assign ent_ts_c = (tbl_wr_en_c && (s3_iss_tag == s2_rc_tag)) ? s3_iss_ts : tbl_rd_ts_c;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_iss_v     <= 1'b0;
      s3_iss_tag   <= '0;
      s3_iss_ts    <= '0;
      s3_rc_v      <= 1'b0;
      s3_rc_close  <= 1'b0;
      s3_rc_err_nz <= 1'b0;
      s3_rc_tag    <= '0;
      s3_lat       <= '0;
    end else begin
      s3_iss_v     <= s2_iss_v;
      s3_iss_tag   <= s2_iss_tag;
      s3_iss_ts    <= s2_ts;
      s3_rc_v      <= s2_rc_v;
      s3_rc_close  <= s2_rc_close;
      s3_rc_err_nz <= s2_rc_err_nz;
      s3_rc_tag    <= s2_rc_tag;
      s3_lat       <= s2_ts - ent_ts_c;
    end
  end

  pci_pa_tag_table #(
    .TAG_WIDTH (TAG_WIDTH),
    .TS_WIDTH  (TS_WIDTH)
  ) u_tag_table (
    .user_clk (user_clk),
    .reset_n  (reset_n),
    .wr_en    (tbl_wr_en_c),
    .wr_tag   (s3_iss_tag),
    .wr_ts    (s3_iss_ts),
    .clr_en   (rc_hit_c),
    .clr_tag  (s3_rc_tag),
    .bulk_clr (pa_count_reset),
    .rd_tag   (s2_rc_tag),
    .rd_ts_c  (tbl_rd_ts_c),
    .valid    (tbl_valid)
  );

  // Stage 4: close is resolved against the old entry before a same-cycle issue rewrites it
  logic [TS_WIDTH-1:0] lat_min_nxt, lat_max_nxt;
  logic [SUM_W-1:0]    lat_sum_nxt;
  logic [CNT_W-1:0]    lat_count_nxt, reuse_nxt, unexp_nxt, err_nxt;
  logic [OUT_W-1:0]    outstanding_nxt;

  always_comb begin
    lat_min_nxt     = rd_lat_min;
    lat_max_nxt     = rd_lat_max;
    lat_sum_nxt     = rd_lat_sum;
    lat_count_nxt   = rd_lat_count;
    reuse_nxt       = tag_reuse_count;
    unexp_nxt       = unexpected_cmp_count;
    err_nxt         = cmp_err_count;
    outstanding_nxt = rd_outstanding;
    tbl_wr_en_c     = s3_iss_v & pa_count_enable & ~pa_count_reset;
    rc_close_c      = s3_rc_v & s3_rc_close & ~pa_count_reset;
    rc_hit_c        = rc_close_c & tbl_valid[s3_rc_tag];
    iss_was_valid_c = tbl_valid[s3_iss_tag] & ~(rc_hit_c & (s3_rc_tag == s3_iss_tag));
    if (pa_count_reset) begin
      lat_min_nxt     = '1;
      lat_max_nxt     = '0;
      lat_sum_nxt     = '0;
      lat_count_nxt   = '0;
      reuse_nxt       = '0;
      unexp_nxt       = '0;
      err_nxt         = '0;
      outstanding_nxt = '0;
    end else begin
      if (rc_hit_c && pa_count_enable) begin
        lat_count_nxt = rd_lat_count + CNT_W'(1);
        lat_sum_nxt   = rd_lat_sum + SUM_W'(s3_lat);
        if (s3_lat < rd_lat_min) lat_min_nxt = s3_lat;
        if (s3_lat > rd_lat_max) lat_max_nxt = s3_lat;
      end
      if (rc_close_c && !tbl_valid[s3_rc_tag] && pa_count_enable)
        unexp_nxt = unexpected_cmp_count + CNT_W'(1);
      if (s3_rc_v && s3_rc_err_nz && pa_count_enable)
        err_nxt = cmp_err_count + CNT_W'(1);
      if (tbl_wr_en_c && iss_was_valid_c)
        reuse_nxt = tag_reuse_count + CNT_W'(1);
      outstanding_nxt = rd_outstanding - OUT_W'(rc_hit_c)
                      + OUT_W'(tbl_wr_en_c & ~iss_was_valid_c);
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_lat_min           <= '1;
      rd_lat_max           <= '0;
      rd_lat_sum           <= '0;
      rd_lat_count         <= '0;
      tag_reuse_count      <= '0;
      unexpected_cmp_count <= '0;
      cmp_err_count        <= '0;
      rd_outstanding       <= '0;
    end else begin
      rd_lat_min           <= lat_min_nxt;
      rd_lat_max           <= lat_max_nxt;
      rd_lat_sum           <= lat_sum_nxt;
      rd_lat_count         <= lat_count_nxt;
      tag_reuse_count      <= reuse_nxt;
      unexpected_cmp_count <= unexp_nxt;
      cmp_err_count        <= err_nxt;
      rd_outstanding       <= outstanding_nxt;
    end
  end

endmodule
